if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- Pipeline register between the fetch stage and the decode stage of the 16-bit pipelined core.
- Captures the fetched instruction and PC+2 each cycle, and holds them on a decode-side stall.
- Injects a NOP bubble on flush.
- Detects a HALT in the fetched stream and drives the fetch stage's halt input so the PC freezes. A 3-state FSM controls how the HALT drains into decode.

Parameters:
- WIDTH, 16, datapath width for instruction and PC.
- NOP_INS, 16'h0800, bubble instruction (opcode 5'b00001).
- HALT_OP, 5'b00000, opcode value in ins[15:11] that identifies HALT.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ins_in  input  WIDTH  instruction from fetch.
- PC_2_in  input  WIDTH  PC+2 from fetch.
- valid_in  input  1  fetch output is a real instruction.
- stall  input  1  decode hazard; hold current contents.
- flush  input  1  branch/jump redirect; squash the stage.
- ins_out  output  WIDTH  registered instruction to decode.
- PC_2_out  output  WIDTH  registered PC+2 to decode.
- valid_out  output  1  ins_out is real (not a bubble).
- halt_fetch  output  1  freeze fetch PC; wired to fetch halt input.
- stall_cnt  output  16  saturating count of stalled cycles, for debug.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: ins_out=NOP_INS, PC_2_out=0, valid_out=0, state=RUN, halt_fetch=0, stall_cnt=0.
- Reset has priority over every other input. Reset mid-HALT_PEND or mid-HALTED returns the block to RUN.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- halt_fetch = (state != RUN). It is decoded from registered state only; no combinational path from ins_in.
- is_halt = valid_in && (ins_in[15:11] == HALT_OP).
- Priority order for each edge: rst > flush > stall > normal capture.
- flush, any state: load NOP_INS, PC_2_out unchanged, valid_out=0; next state RUN. flush with stall drops the stall. flush in HALT_PEND cancels the halt (HALT was in a branch shadow); halt_fetch deasserts the next cycle.
- stall and not flush: all data registers hold; state holds; stall_cnt increments, saturating at 16'hFFFF.
- RUN, not stall, not flush: load ins_in, PC_2_in, valid_in. If is_halt, next state is HALT_PEND; otherwise stay in RUN.
- HALT_PEND: the HALT instruction is on the outputs and the fetch PC is frozen.
  - If not stall and not flush: load NOP_INS with valid_out=0; next state HALTED.
  - Inputs are ignored. The fetch output while frozen is not captured.
- HALTED: data registers hold the bubble. The block leaves HALTED only on flush or rst.
- A second is_halt on ins_in while in HALT_PEND or HALTED is ignored.
- stall_cnt does not count flush cycles. It is cleared only by rst.
- State encoding: 2 bits; RUN=2'b00, HALT_PEND=2'b01, HALTED=2'b10. 2'b11 is illegal and is forced to RUN with a bubble on the next edge.

Decomposition:
- Shared package/include holds the constants NOP_INS, HALT_OP, the state encodings, and WIDTH.
- One sub-module: dff_en, a WIDTH-parameterised register with load enable, built on the existing dff cell with a synchronous active-high reset value input.
- Instances in if_id_reg:
  - ins_out register, reset value NOP_INS.
  - PC_2_out register, reset value 0.
  - valid_out register, 1 bit.
  - state register, 2 bits.
  - stall_cnt register, 16 bits.

Test Plan:
- Reset then stream: rst=1 for 2 cycles, then ins_in=16'hC005, PC_2_in=16'h0002, valid_in=1 -> after reset ins_out=16'h0800, valid_out=0; one edge later ins_out=16'hC005, PC_2_out=16'h0002, valid_out=1.
- Stall hold: hold stall=1 for 3 cycles while ins_in changes to 16'h4321 -> ins_out stays 16'hC005, stall_cnt=3; after release ins_out=16'h4321.
- Flush priority: stall=1 and flush=1 in the same cycle -> next ins_out=16'h0800, valid_out=0, stall_cnt unchanged.
- Halt drain: capture ins_in=16'h0000, valid_in=1 -> halt_fetch=1, ins_out=16'h0000. Next non-stall edge -> ins_out=16'h0800, valid_out=0, state HALTED. Apply a new ins_in=16'h1234 -> ignored.
- Halt cancelled: HALT captured, then flush=1 in HALT_PEND -> halt_fetch=0 next cycle, state RUN; the next fetched instruction 16'h9001 is captured normally.
- Saturation and reset: stall=1 for 70000 cycles -> stall_cnt=16'hFFFF. Assert rst while in HALTED -> all outputs return to their reset values.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared constants and state encodings for the fetch/decode pipeline register.
package if_id_pkg;
   localparam int          WIDTH   = 16;
   localparam logic [15:0] NOP_INS = 16'h0800;
   localparam logic [4:0]  HALT_OP = 5'b00000;

   typedef enum logic [1:0] {
      ST_RUN       = 2'b00,
      ST_HALT_PEND = 2'b01,
      ST_HALTED    = 2'b10
   } state_t;
endpackage

// File: rtl/if_id_reg_dff_en.sv
// Load-enabled register with a synchronous active-high reset to a supplied value.
// Latency 1 cycle; holds its contents whenever en is low.
module dff_en #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] rst_val,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst)     q <= rst_val;
      else if (en) q <= d;
   end
endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: 1-cycle capture, holds on stall, bubbles on flush,
// and freezes fetch (halt_fetch) from registered state once a HALT is captured.
module if_id_reg
   import if_id_pkg::*;
#(
   parameter int          WIDTH    = if_id_pkg::WIDTH,
   parameter logic [15:0] NOP_INS  = if_id_pkg::NOP_INS,
   parameter logic [4:0]  HALT_OP  = if_id_pkg::HALT_OP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ins_in,
   input  logic [WIDTH-1:0] PC_2_in,
   input  logic             valid_in,
   input  logic             stall,
   input  logic             flush,
   output logic [WIDTH-1:0] ins_out,
   output logic [WIDTH-1:0] PC_2_out,
   output logic             valid_out,
   output logic             halt_fetch,
   output logic [15:0]      stall_cnt
);
   localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_INS);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] ins_d;
   logic             ins_en, pc_en, vld_d, vld_en, cnt_en;
   logic             is_halt;

   assign is_halt = valid_in && (ins_in[WIDTH-1 -: 5] == HALT_OP);

   always_comb begin
      state_d = state_q;
      ins_d   = ins_in;
      ins_en  = 1'b0;
      pc_en   = 1'b0;
      vld_d   = valid_in;
      vld_en  = 1'b0;
      // Flush and the unused encoding both collapse to a bubble in RUN, even under stall.
      if (flush || state_q == 2'b11) begin
         ins_d   = NOP_W;
         ins_en  = 1'b1;
         vld_d   = 1'b0;
         vld_en  = 1'b1;
         state_d = ST_RUN;
      end else if (!stall) begin
         case (state_q)
            ST_RUN: begin
               ins_en  = 1'b1;
               pc_en   = 1'b1;
               vld_en  = 1'b1;
               state_d = is_halt ? ST_HALT_PEND : ST_RUN;
            end
            ST_HALT_PEND: begin
               ins_d   = NOP_W;
               ins_en  = 1'b1;
               vld_d   = 1'b0;
               vld_en  = 1'b1;
               state_d = ST_HALTED;
            end
            default: state_d = state_q;
         endcase
      end
   end

   assign cnt_en     = stall && !flush && (stall_cnt != 16'hFFFF);
   assign halt_fetch = (state_q != ST_RUN);

   dff_en #(.W(WIDTH)) u_ins (
      .clk(clk), .rst(rst), .en(ins_en), .rst_val(NOP_W), .d(ins_d), .q(ins_out)
   );

   dff_en #(.W(WIDTH)) u_pc (
      .clk(clk), .rst(rst), .en(pc_en), .rst_val({WIDTH{1'b0}}), .d(PC_2_in), .q(PC_2_out)
   );

   dff_en #(.W(1)) u_vld (
      .clk(clk), .rst(rst), .en(vld_en), .rst_val(1'b0), .d(vld_d), .q(valid_out)
   );

   dff_en #(.W(2)) u_state (
      .clk(clk), .rst(rst), .en(1'b1), .rst_val(ST_RUN), .d(state_d), .q(state_q)
   );

   dff_en #(.W(16)) u_cnt (
      .clk(clk), .rst(rst), .en(cnt_en), .rst_val(16'h0000), .d(stall_cnt + 16'd1), .q(stall_cnt)
   );
endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg with a cycle-by-cycle reference model.
module tb_if_id_reg;
   logic        clk = 1'b0;
   logic        rst, valid_in, stall, flush;
   logic [15:0] ins_in, PC_2_in;
   logic [15:0] ins_out, PC_2_out, stall_cnt;
   logic        valid_out, halt_fetch;

   int n_cmp = 0;
   int n_bad = 0;

   if_id_reg dut (
      .clk(clk), .rst(rst), .ins_in(ins_in), .PC_2_in(PC_2_in), .valid_in(valid_in),
      .stall(stall), .flush(flush), .ins_out(ins_out), .PC_2_out(PC_2_out),
      .valid_out(valid_out), .halt_fetch(halt_fetch), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: "frozen" means a HALT has been accepted and fetch must stop;
   // "drained" means the bubble after the HALT has already been delivered.
   logic [15:0] m_ins, m_pc, m_cnt;
   logic        m_vld;
   bit          m_frozen, m_drained, m_live = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_ins = 16'h0800; m_pc = 16'h0; m_vld = 0; m_cnt = 0;
         m_frozen = 0; m_drained = 0; m_live = 1;
      end else if (flush) begin
         m_ins = 16'h0800; m_vld = 0; m_frozen = 0; m_drained = 0;
      end else if (stall) begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (!m_frozen) begin
         m_ins = ins_in; m_pc = PC_2_in; m_vld = valid_in;
         if (valid_in && ins_in[15:11] == 5'b00000) m_frozen = 1;
      end else if (!m_drained) begin
         m_ins = 16'h0800; m_vld = 0; m_drained = 1;
      end
      #1;
      if (m_live) begin
         chk("model_ins", ins_out, m_ins);
         chk("model_pc", PC_2_out, m_pc);
         chk("model_vld", {15'b0, valid_out}, {15'b0, m_vld});
         chk("model_halt", {15'b0, halt_fetch}, {15'b0, m_frozen});
         chk("model_cnt", stall_cnt, m_cnt);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1; valid_in = 0; stall = 0; flush = 0; ins_in = 16'h0; PC_2_in = 16'h0;
      cyc(2);
      chk("rst_ins", ins_out, 16'h0800);
      chk("rst_pc", PC_2_out, 16'h0000);
      chk("rst_vld", {15'b0, valid_out}, 16'h0);
      chk("rst_halt", {15'b0, halt_fetch}, 16'h0);
      chk("rst_cnt", stall_cnt, 16'h0);

      rst = 0; ins_in = 16'hC005; PC_2_in = 16'h0002; valid_in = 1;
      cyc();
      chk("cap_ins", ins_out, 16'hC005);
      chk("cap_pc", PC_2_out, 16'h0002);
      chk("cap_vld", {15'b0, valid_out}, 16'h1);

      stall = 1; ins_in = 16'h4321; PC_2_in = 16'h0004;
      cyc(3);
      chk("stall_ins", ins_out, 16'hC005);
      chk("stall_cnt", stall_cnt, 16'd3);
      stall = 0;
      cyc();
      chk("release_ins", ins_out, 16'h4321);
      chk("release_pc", PC_2_out, 16'h0004);

      stall = 1; flush = 1;
      cyc();
      chk("flush_ins", ins_out, 16'h0800);
      chk("flush_vld", {15'b0, valid_out}, 16'h0);
      chk("flush_pc", PC_2_out, 16'h0004);
      chk("flush_cnt", stall_cnt, 16'd3);
      stall = 0; flush = 0;

      ins_in = 16'h0000; PC_2_in = 16'h0006; valid_in = 1;
      cyc();
      chk("halt_ins", ins_out, 16'h0000);
      chk("halt_fetch", {15'b0, halt_fetch}, 16'h1);
      ins_in = 16'h1234; PC_2_in = 16'h0008;
      cyc();
      chk("drain_ins", ins_out, 16'h0800);
      chk("drain_vld", {15'b0, valid_out}, 16'h0);
      chk("drain_pc", PC_2_out, 16'h0006);
      cyc();
      chk("halted_ins", ins_out, 16'h0800);
      chk("halted_fetch", {15'b0, halt_fetch}, 16'h1);
      ins_in = 16'h0000;
      cyc();
      chk("halted_rehalt", ins_out, 16'h0800);

      flush = 1;
      cyc();
      chk("unhalt_fetch", {15'b0, halt_fetch}, 16'h0);
      flush = 0; ins_in = 16'h0000; PC_2_in = 16'h000A;
      cyc();
      chk("pend_fetch", {15'b0, halt_fetch}, 16'h1);
      flush = 1;
      cyc();
      chk("cancel_fetch", {15'b0, halt_fetch}, 16'h0);
      chk("cancel_ins", ins_out, 16'h0800);
      chk("cancel_pc", PC_2_out, 16'h000A);
      flush = 0; ins_in = 16'h9001; PC_2_in = 16'h000C;
      cyc();
      chk("resume_ins", ins_out, 16'h9001);
      chk("resume_vld", {15'b0, valid_out}, 16'h1);

      ins_in = 16'h0000; PC_2_in = 16'h000E; valid_in = 0;
      cyc();
      chk("invalid_halt_ins", ins_out, 16'h0000);
      chk("invalid_halt_fetch", {15'b0, halt_fetch}, 16'h0);

      valid_in = 1;
      cyc();
      ins_in = 16'h1111;
      cyc();
      chk("to_halted", {15'b0, halt_fetch}, 16'h1);
      stall = 1;
      cyc(70000);
      chk("sat_cnt", stall_cnt, 16'hFFFF);
      stall = 0; rst = 1;
      cyc();
      chk("rst2_ins", ins_out, 16'h0800);
      chk("rst2_pc", PC_2_out, 16'h0000);
      chk("rst2_vld", {15'b0, valid_out}, 16'h0);
      chk("rst2_halt", {15'b0, halt_fetch}, 16'h0);
      chk("rst2_cnt", stall_cnt, 16'h0);
      rst = 0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
